// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial subtractor: computes Diff = A - B - Bin (mod 2^WIDTH) one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow register.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   start  : begin a subtraction (accepted in IDLE or DONE, ignored in RUN)
//   A, B   : minuend / subtrahend, captured on an accepted start
//   Bin    : borrow-in, captured on an accepted start
//   busy   : high while the operation is in progress (RUN)
//   done   : one-cycle pulse, Diff/Bout valid
//   Diff   : result, held from the DONE cycle until it is overwritten
//   Bout   : final borrow-out (A < B + Bin)
module serial_ripple_borrow_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               br;
    logic [CNT_W-1:0]   cnt;

    logic               accept_c;
    logic               last_bit_c;
    logic               d_c;
    logic               br_next_c;
    logic [WIDTH-1:0]   res_next_c;

    // Full-subtractor cell on the current LSBs and the borrow register
    always_comb begin
        d_c        = a_sr[0] ^ b_sr[0] ^ br;
        br_next_c  = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
        // New bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
        res_next_c = {d_c, res_sr[WIDTH-1:1]};
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_bit_c = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last_bit_c = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept_c) begin
                a_sr   <= A;
                b_sr   <= B;
                br     <= Bin;
                res_sr <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                br     <= br_next_c;
                res_sr <= res_next_c;
                cnt    <= cnt + CNT_W'(1);
                // Outputs change only when the full result is available
                if (last_bit_c) begin
                    Diff <= res_next_c;
                    Bout <= br_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_ripple_borrow_subtractor.sv
// Directed and exhaustive checks for serial_ripple_borrow_subtractor (WIDTH=4).
module tb_serial_ripple_borrow_subtractor;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;

    int n_cmp;
    int n_err;

    serial_ripple_borrow_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts one operation from IDLE/DONE and checks the full latency profile.
    // Operands are scrambled right after acceptance to prove they were captured.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] exp_d, input logic exp_bo);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
        for (int i = 0; i < int'(W); i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("diff", 32'(Diff), 32'(exp_d));
        chk("bout", 32'(Bout), 32'(exp_bo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        logic [W-1:0] seen_diff;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, diff: 4'h6, bout: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, diff: 4'hA, bout: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'hF, bout: 1'b1};
        vecs[3] = '{a: 4'd5,  b: 4'd7,  bin: 1'b1, diff: 4'hD, bout: 1'b1};
        vecs[4] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, diff: 4'hF, bout: 1'b0};
        vecs[5] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, diff: 4'h0, bout: 1'b1};
        vecs[6] = '{a: 4'd8,  b: 4'd8,  bin: 1'b0, diff: 4'h0, bout: 1'b0};
        vecs[7] = '{a: 4'd7,  b: 4'd6,  bin: 1'b1, diff: 4'h0, bout: 1'b0};
        vecs[8] = '{a: 4'd6,  b: 4'd6,  bin: 1'b1, diff: 4'hF, bout: 1'b1};
        vecs[9] = '{a: 4'd12, b: 4'd5,  bin: 1'b0, diff: 4'h7, bout: 1'b0};

        // Reset state
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_bout", 32'(Bout), 32'd0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("diff_hold", 32'(Diff), 32'(vecs[i].diff));
        end

        // Start asserted during RUN is ignored
        A = 4'd9; B = 4'd3; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 4'd1; B = 4'd1;
        busy_cnt = 0; done_cnt = 0; seen_diff = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                seen_diff = Diff;
            end
            @(negedge clk);
        end
        chk("ign_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("ign_done_count", 32'(done_cnt), 32'd1);
        chk("ign_diff", 32'(seen_diff), 32'h6);

        // Back-to-back: second start issued in the DONE cycle
        run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0);
        run_op(4'd5, 4'd7, 1'b1, 4'hD, 1'b1);
        @(negedge clk);
        chk("b2b_idle_done", 32'(done), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);

        // Reset at the 2nd RUN edge aborts with no done and no partial result
        A = 4'd3; B = 4'd9; Bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(Diff), 32'd0);
        chk("abort_bout", 32'(Bout), 32'd0);
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_no_busy", 32'(busy_cnt), 32'd0);

        // Reset wins over a simultaneous start
        rst = 1'b1; start = 1'b1; A = 4'd5; B = 4'd1; Bin = 1'b0;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_pri_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rst_pri_busy2", 32'(busy), 32'd0);
        chk("rst_pri_done2", 32'(done), 32'd0);

        // Exhaustive sweep against an arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int r;
                    r = a - b - c;
                    run_op(4'(a), 4'(b), 1'(c), 4'(r), 1'(r < 0));
                end
            end
        end
        @(negedge clk);
        chk("sweep_end_done", 32'(done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
